// File: rtl/cpu_pkg.sv
// Shared CPU definitions: sequencer state encodings and instruction width.
package cpu_pkg;

    localparam int unsigned INSTR_W = 16;

    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_EXEC1 = 2'b01,
        ST_EXEC2 = 2'b10,
        ST_HALT  = 2'b11
    } state_e;

endpackage

// File: rtl/retire_counter.sv
// Enable-count register with asynchronous active-low clear; wraps at 2^CNT_W.
module retire_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (en_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/cpu_sequencer.sv
// FETCH/EXEC1/EXEC2/HALT instruction sequencer with IR, jump-history flag,
// halt/resume, single-step and retired-instruction counter.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter logic [INSTR_W-1:0] IR_RESET = 16'h0000,
    parameter int unsigned        CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INSTR_W-1:0] instr_rdata,
    input  logic               sm_extra,
    input  logic               stop,
    input  logic               set_jump,
    input  logic               resume,
    input  logic               step_mode,
    output logic [1:0]         state,
    output logic [INSTR_W-1:0] instruction,
    output logic               jump,
    output logic               halted,
    output logic [CNT_W-1:0]   retired_count
);

    state_e             state_q, state_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               jump_q, jump_d;
    logic               complete;
    logic               ir_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_FETCH: state_d = stop ? ST_HALT : ST_EXEC1;
            ST_EXEC1: begin
                if (stop) begin
                    state_d = ST_HALT;
                end else if (sm_extra) begin
                    state_d = ST_EXEC2;
                end else begin
                    state_d = step_mode ? ST_HALT : ST_FETCH;
                end
            end
            ST_EXEC2: begin
                if (stop || step_mode) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_HALT:  state_d = resume ? ST_FETCH : ST_HALT;
            default:  state_d = ST_FETCH;
        endcase
    end

    // A stop exit never counts as a completion.
    always_comb begin
        complete = 1'b0;
        ir_load  = 1'b0;
        unique case (state_q)
            ST_FETCH: ir_load  = !stop;
            ST_EXEC1: complete = !stop && !sm_extra;
            ST_EXEC2: complete = !stop;
            ST_HALT:  complete = 1'b0;
            default:  complete = 1'b0;
        endcase
    end

    always_comb begin
        ir_d = ir_q;
        if (ir_load) begin
            ir_d = instr_rdata;
        end
    end

    // Set wins over clear; clear only on the edge that leaves EXEC1.
    always_comb begin
        jump_d = jump_q;
        if (set_jump) begin
            jump_d = 1'b1;
        end else if (state_q == ST_EXEC1) begin
            jump_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_q   <= IR_RESET;
            jump_q <= 1'b0;
        end else begin
            ir_q   <= ir_d;
            jump_q <= jump_d;
        end
    end

    retire_counter #(
        .CNT_W(CNT_W)
    ) u_retire_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (complete),
        .count_o(retired_count)
    );

    assign state       = state_q;
    assign halted      = (state_q == ST_HALT);
    assign instruction = ir_q;
    assign jump        = jump_q;

endmodule
